y86_mem_arbiter: RTL

//   Shares one memory port between the pipeline's fetch stage (80-bit instruction reads) and its

---
 rtl/y86_mem_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/y86_mem_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch (10-byte reads) and memory stage (8-byte reads/writes).
// Optional ARB_PERF_CNT_EN adds grant and conflict counters.
module y86_mem_arbiter #(
    parameter int MEM_BYTES   = 4096,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req_i,
    input  logic [63:0] f_addr_i,
    output logic        f_ack_o,
    output logic [79:0] f_rdata_o,
    output logic        f_err_o,
    output logic        f_wait_o,
    input  logic        m_req_i,
    input  logic        m_we_i,
    input  logic [63:0] m_addr_i,
    input  logic [63:0] m_wdata_i,
    output logic        m_ack_o,
    output logic [63:0] m_rdata_o,
    output logic        m_err_o,
    output logic        m_wait_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic        mem_len_o,
    input  logic        mem_ack_i,
    input  logic [79:0] mem_rdata_i,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] perf_f_grants_o,
    output logic [31:0] perf_m_grants_o,
    output logic [31:0] perf_conflicts_o,
`endif
    output logic [1:0]  dbg_state_o
);

    // Handshake: a requester holds x_req and its operands until the single-cycle x_ack;
    // the memory side sees mem_req with stable operands until the cycle it returns mem_ack.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_M = 2'd1,
        BUSY_F = 2'd2
    } state_e;

    localparam int                CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [64:0]       MEM_LIMIT = 65'(MEM_BYTES);

    state_e             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [63:0]        mem_addr_q, mem_addr_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;
    logic               mem_len_q, mem_len_d;
    logic               bad_q, bad_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               f_ack_q, f_ack_d;
    logic               f_err_q, f_err_d;
    logic [79:0]        f_rdata_q, f_rdata_d;
    logic               m_ack_q, m_ack_d;
    logic               m_err_q, m_err_d;
    logic [63:0]        m_rdata_q, m_rdata_d;

    logic arb_en, excl_m, excl_f, m_elig, f_elig, grant_m, grant_f;
    logic done, done_err, m_bad, f_bad;

    // 65-bit sums so a wrap past 2^64 still reads as out of range.
    assign m_bad = ({1'b0, m_addr_i} + 65'd7) >= MEM_LIMIT;
    assign f_bad = ({1'b0, f_addr_i} + 65'd9) >= MEM_LIMIT;

    assign m_elig  = m_req_i & ~excl_m;
    assign f_elig  = f_req_i & ~excl_f;
    assign grant_m = arb_en & m_elig;
    assign grant_f = arb_en & f_elig & ~m_elig;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_len_d   = mem_len_q;
        bad_d       = bad_q;
        cnt_d       = cnt_q;
        f_ack_d     = 1'b0;
        f_err_d     = 1'b0;
        f_rdata_d   = f_rdata_q;
        m_ack_d     = 1'b0;
        m_err_d     = 1'b0;
        m_rdata_d   = m_rdata_q;
        arb_en      = 1'b0;
        excl_m      = 1'b0;
        excl_f      = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;

        case (state_q)
            IDLE: arb_en = 1'b1;
            BUSY_M, BUSY_F: begin
                if (bad_q) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    bad_d    = 1'b0;
                    state_d  = IDLE;
                end else if (mem_ack_i) begin
                    // Completion wins over a timeout landing in the same cycle.
                    done      = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    arb_en    = 1'b1;
                    excl_m    = (state_q == BUSY_M);
                    excl_f    = (state_q == BUSY_F);
                end else if (cnt_q == CNT_LAST) begin
                    done      = 1'b1;
                    done_err  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (state_q == BUSY_M) begin
                m_ack_d   = 1'b1;
                m_err_d   = done_err;
                m_rdata_d = (done_err | mem_we_q) ? 64'h0 : mem_rdata_i[63:0];
            end else begin
                f_ack_d   = 1'b1;
                f_err_d   = done_err;
                f_rdata_d = done_err ? 80'h0 : mem_rdata_i;
            end
        end

        if (grant_m) begin
            state_d     = BUSY_M;
            cnt_d       = '0;
            mem_we_d    = m_we_i;
            mem_addr_d  = m_addr_i;
            mem_wdata_d = m_wdata_i;
            mem_len_d   = 1'b0;
            bad_d       = m_bad;
            mem_req_d   = ~m_bad;
        end else if (grant_f) begin
            state_d     = BUSY_F;
            cnt_d       = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr_i;
            mem_wdata_d = 64'h0;
            mem_len_d   = 1'b1;
            bad_d       = f_bad;
            mem_req_d   = ~f_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'h0;
            mem_wdata_q <= 64'h0;
            mem_len_q   <= 1'b0;
            bad_q       <= 1'b0;
            cnt_q       <= '0;
            f_ack_q     <= 1'b0;
            f_err_q     <= 1'b0;
            f_rdata_q   <= 80'h0;
            m_ack_q     <= 1'b0;
            m_err_q     <= 1'b0;
            m_rdata_q   <= 64'h0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_len_q   <= mem_len_d;
            bad_q       <= bad_d;
            cnt_q       <= cnt_d;
            f_ack_q     <= f_ack_d;
            f_err_q     <= f_err_d;
            f_rdata_q   <= f_rdata_d;
            m_ack_q     <= m_ack_d;
            m_err_q     <= m_err_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_f_q, perf_m_q, perf_c_q;

    // A just-completed requester is not a contender, so it never counts as a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_f_q <= 32'h0;
            perf_m_q <= 32'h0;
            perf_c_q <= 32'h0;
        end else begin
            if (grant_f)                    perf_f_q <= perf_f_q + 32'd1;
            if (grant_m)                    perf_m_q <= perf_m_q + 32'd1;
            if (arb_en & m_elig & f_elig)   perf_c_q <= perf_c_q + 32'd1;
        end
    end

    assign perf_f_grants_o  = perf_f_q;
    assign perf_m_grants_o  = perf_m_q;
    assign perf_conflicts_o = perf_c_q;
`endif

    assign f_ack_o     = f_ack_q;
    assign f_err_o     = f_err_q;
    assign f_rdata_o   = f_rdata_q;
    assign f_wait_o    = f_req_i & ~f_ack_q;
    assign m_ack_o     = m_ack_q;
    assign m_err_o     = m_err_q;
    assign m_rdata_o   = m_rdata_q;
    assign m_wait_o    = m_req_i & ~m_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_len_o   = mem_len_q;
    assign dbg_state_o = state_q;

endmodule
